// File: rtl/mux2_pkg.sv
// -----------------------------------------------------------------------------
// mux2_pkg
// Shared definitions for the registered 2:1 multiplexer slice.
//   MUX2_DEF_WIDTH : default data width of the mux datapath
//   MUX2_DEF_CNT_W : default width of the select-change counter
//   mux2_sel_e     : symbolic select encoding (SEL_D0 / SEL_D1)
//   mux2_sel_changed() : select-change detect used by the optional counter
// Optional feature macro used by importers: MUX2_SWITCH_CNT_EN
// -----------------------------------------------------------------------------
package mux2_pkg;

    localparam int MUX2_DEF_WIDTH = 1;
    localparam int MUX2_DEF_CNT_W = 8;

    typedef enum logic {
        SEL_D0 = 1'b0,
        SEL_D1 = 1'b1
    } mux2_sel_e;

    // True when the current select differs from the last captured one.
    function automatic logic mux2_sel_changed(input mux2_sel_e cur_sel,
                                              input mux2_sel_e last_sel);
        return (cur_sel != last_sel);
    endfunction

endpackage : mux2_pkg

// File: rtl/mux2_sel_comb.sv
// -----------------------------------------------------------------------------
// mux2_sel_comb
// Purely combinational WIDTH-bit 2:1 select: z_o = sel_i ? d1_i : d0_i.
// Its output feeds both the zero-latency z_comb port and the z register.
// Ports:
//   d0_i  [WIDTH-1:0] : data chosen when sel_i = 0
//   d1_i  [WIDTH-1:0] : data chosen when sel_i = 1
//   sel_i             : select
//   z_o   [WIDTH-1:0] : selected data
// -----------------------------------------------------------------------------
module mux2_sel_comb
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] z_o
);

    mux2_sel_e sel_e;
    assign sel_e = mux2_sel_e'(sel_i);

    // Per-bit select keeps the mapping to one LUT input set per bit obvious.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign z_o[gi] = (sel_e == SEL_D1) ? d1_i[gi] : d0_i[gi];
        end
    endgenerate

endmodule : mux2_sel_comb

// File: rtl/mux2_reg.sv
// -----------------------------------------------------------------------------
// mux2_reg
// Registered, width-parameterised 2:1 multiplexer for the datapath select
// stage. Each enabled cycle the selected input is captured into z and a
// one-cycle z_valid pulse follows. z_comb gives the same selection with
// zero latency.
//
// Optional feature (macro MUX2_SWITCH_CNT_EN): a last_sel register and a
// saturating counter sw_cnt that counts enabled captures whose select differs
// from the previously captured select. Without the macro the counter,
// last_sel and the sw_cnt port do not exist.
//
// Parameters:
//   WIDTH : data width of d0, d1, z, z_comb
//   CNT_W : width of the select-change counter
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   en      : capture enable
//   d0, d1  : data inputs (d0 when sel = 0, d1 when sel = 1)
//   sel     : select
//   z       : registered mux result
//   z_valid : high for the cycle after a capture
//   z_comb  : combinational sel ? d1 : d0
//   sw_cnt  : select-change count (MUX2_SWITCH_CNT_EN only)
// -----------------------------------------------------------------------------
module mux2_reg
    import mux2_pkg::*;
#(
    parameter int WIDTH = MUX2_DEF_WIDTH,
    parameter int CNT_W = MUX2_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] z,
    output logic             z_valid,
`ifdef MUX2_SWITCH_CNT_EN
    output logic [WIDTH-1:0] z_comb,
    output logic [CNT_W-1:0] sw_cnt
`else
    output logic [WIDTH-1:0] z_comb
`endif
);

    // Reject degenerate configurations at elaboration.
    generate
        if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
            $error("mux2_reg: WIDTH and CNT_W must both be at least 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Combinational select, shared by z_comb and the z register input
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sel_data;

    mux2_sel_comb #(
        .WIDTH (WIDTH)
    ) u_sel_comb (
        .d0_i  (d0),
        .d1_i  (d1),
        .sel_i (sel),
        .z_o   (sel_data)
    );

    assign z_comb = sel_data;

    // -------------------------------------------------------------------------
    // Output register and valid flag
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] z_q;
    logic [WIDTH-1:0] z_d;
    logic             z_valid_q;
    logic             z_valid_d;

    always_comb begin
        z_d       = z_q;
        z_valid_d = 1'b0;
        if (en) begin
            z_d       = sel_data;
            z_valid_d = 1'b1;
        end
    end

    // Asynchronous reset clears the held value and the pulse immediately,
    // so a pending capture is discarded the same instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q       <= '0;
            z_valid_q <= 1'b0;
        end else begin
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
        end
    end

    assign z       = z_q;
    assign z_valid = z_valid_q;

`ifdef MUX2_SWITCH_CNT_EN
    // -------------------------------------------------------------------------
    // Select-change counter
    // last_sel resets to SEL_D0, so a first capture with sel = 1 counts.
    // -------------------------------------------------------------------------
    mux2_sel_e        last_sel_q;
    mux2_sel_e        last_sel_d;
    logic [CNT_W-1:0] sw_cnt_q;
    logic [CNT_W-1:0] sw_cnt_d;
    logic             cnt_sat;

    assign cnt_sat = &sw_cnt_q;

    always_comb begin
        last_sel_d = last_sel_q;
        sw_cnt_d   = sw_cnt_q;
        if (en) begin
            last_sel_d = mux2_sel_e'(sel);
            if (mux2_sel_changed(mux2_sel_e'(sel), last_sel_q) && !cnt_sat) begin
                sw_cnt_d = sw_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sel_q <= SEL_D0;
            sw_cnt_q   <= '0;
        end else begin
            last_sel_q <= last_sel_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign sw_cnt = sw_cnt_q;
`endif

endmodule : mux2_reg

// File: tb/tb_mux2_reg.sv
// -----------------------------------------------------------------------------
// tb_mux2_reg
// Self-checking bench for mux2_reg. Two instances share clk/rst:
//   dut1 : WIDTH=1, CNT_W=8 (truth table, reset, select-change counter)
//   dut8 : WIDTH=8, CNT_W=2 (enable hold, back-to-back, counter saturation)
// Expected z / z_valid / sw_cnt are pushed to a per-instance queue when a
// cycle's stimulus is driven and popped after the following rising edge.
// Counter checks are compiled only with MUX2_SWITCH_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mux2_reg;

    logic clk;
    logic rst;

    // dut1 signals
    logic       en1, d0_1, d1_1, sel1;
    logic       z1, zv1, zc1;
    logic [7:0] cnt1;

    // dut8 signals
    logic       en8, sel8;
    logic [7:0] d0_8, d1_8;
    logic [7:0] z8, zc8;
    logic       zv8;
    logic [1:0] cnt8;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [7:0] z;
        logic       v;
        logic [7:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];

    // Reference model state
    logic [7:0] m_z1, m_z8;
    logic       m_last1, m_last8;
    int         m_cnt1, m_cnt8;

    mux2_reg #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en1),
        .d0      (d0_1),
        .d1      (d1_1),
        .sel     (sel1),
        .z       (z1),
        .z_valid (zv1),
`ifdef MUX2_SWITCH_CNT_EN
        .z_comb  (zc1),
        .sw_cnt  (cnt1)
`else
        .z_comb  (zc1)
`endif
    );

    mux2_reg #(.WIDTH(8), .CNT_W(2)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .en      (en8),
        .d0      (d0_8),
        .d1      (d1_8),
        .sel     (sel8),
        .z       (z8),
        .z_valid (zv8),
`ifdef MUX2_SWITCH_CNT_EN
        .z_comb  (zc8),
        .sw_cnt  (cnt8)
`else
        .z_comb  (zc8)
`endif
    );

`ifndef MUX2_SWITCH_CNT_EN
    initial begin
        cnt1 = '0;
        cnt8 = '0;
    end
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the bench is clock-driven, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Stimulus + scoreboard push (no comparisons here)
    // ---------------------------------------------------------------------
    task automatic drive1(input logic e, input logic a, input logic b, input logic s);
        exp_t x;
        en1 = e; d0_1 = a; d1_1 = b; sel1 = s;
        if (e) begin
            m_z1 = {7'd0, (s ? b : a)};
            if (s != m_last1 && m_cnt1 != 255) m_cnt1++;
            m_last1 = s;
        end
        x.z = m_z1; x.v = e; x.cnt = 8'(m_cnt1);
        q1.push_back(x);
    endtask

    task automatic drive8(input logic e, input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t x;
        en8 = e; d0_8 = a; d1_8 = b; sel8 = s;
        if (e) begin
            m_z8 = s ? b : a;
            if (s != m_last8 && m_cnt8 != 3) m_cnt8++;
            m_last8 = s;
        end
        x.z = m_z8; x.v = e; x.cnt = 8'(m_cnt8);
        q8.push_back(x);
    endtask

    task automatic model_reset();
        q1.delete(); q8.delete();
        m_z1 = '0; m_z8 = '0;
        m_last1 = 1'b0; m_last8 = 1'b0;
        m_cnt1 = 0; m_cnt8 = 0;
    endtask

    // Assert rst mid-cycle, release one time unit after the next edge.
    task automatic do_reset();
        en1 = 1'b0; en8 = 1'b0;
        #3 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        exp_t e;
        // Power-on reset state
        @(posedge clk); #1;
        n_checks++;
        if (z1 !== 1'b0 || zv1 !== 1'b0 || z8 !== 8'h00 || zv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: z1=%b zv1=%b z8=%h zv8=%b, required all 0", z1, zv1, z8, zv8);
        end
`ifdef MUX2_SWITCH_CNT_EN
        n_checks++;
        if (cnt1 !== 8'd0 || cnt8 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: cnt1=%0d cnt8=%0d, required 0", cnt1, cnt8);
        end
`endif
        rst = 1'b0;
        model_reset();

        // Load z=1
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        e = q1.pop_front();
        n_checks++;
        if (z1 !== e.z[0] || zv1 !== e.v) begin
            n_fail++;
            $display("FAIL reset_preload: z=%b zv=%b, required z=%b zv=%b", z1, zv1, e.z[0], e.v);
        end

        // Mid-cycle async reset: outputs clear before the next edge
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (z1 !== 1'b0 || zv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: z=%b zv=%b, required 0 0 before next edge", z1, zv1);
        end
`ifdef MUX2_SWITCH_CNT_EN
        n_checks++;
        if (cnt1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async_cnt: cnt=%0d, required 0", cnt1);
        end
`endif
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (z1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: z=%b, required 0 right after release", z1);
        end

        // First capture after release: en=1, d1=1, sel=1
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        e = q1.pop_front();
        n_checks++;
        if (z1 !== 1'b1 || z1 !== e.z[0] || zv1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_capture: z=%b zv=%b, required z=1 zv=1", z1, zv1);
        end
        $display("test_reset done");
    endtask

    task automatic test_truth_table();
        int   tt_in   [8] = '{0, 1, 2, 3, 5, 4, 6, 7}; // (d0,d1,sel) as 3-bit value
        logic tt_req  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_t e;
        logic a, b, s;
        for (int i = 0; i < 8; i++) begin
            a = tt_in[i][2]; b = tt_in[i][1]; s = tt_in[i][0];
            // Hold each combination for 8 cycles = 80 time units.
            for (int c = 0; c < 8; c++) begin
                drive1(1'b1, a, b, s);
                if (c == 0) begin
                    #1;
                    n_checks++;
                    if (zc1 !== tt_req[i]) begin
                        n_fail++;
                        $display("FAIL truth_comb[%0d]: z_comb=%b, required %b", i, zc1, tt_req[i]);
                    end
                end
                @(posedge clk); #1;
                e = q1.pop_front();
                if (c == 0) begin
                    n_checks++;
                    if (z1 !== tt_req[i] || z1 !== e.z[0] || zv1 !== e.v) begin
                        n_fail++;
                        $display("FAIL truth_reg[%0d]: z=%b zv=%b, required z=%b zv=%b", i, z1, zv1, tt_req[i], e.v);
                    end
                end
            end
            $display("truth %0d%0d%0d -> z_comb=%b z=%b", a, b, s, zc1, z1);
        end
    endtask

    task automatic test_enable_hold();
        exp_t e;
        drive8(1'b1, 8'hA5, 8'h00, 1'b0);
        @(posedge clk); #1;
        e = q8.pop_front();
        n_checks++;
        if (z8 !== 8'hA5 || z8 !== e.z || zv8 !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_capture: z=%h zv=%b, required z=a5 zv=1", z8, zv8);
        end
        for (int c = 0; c < 3; c++) begin
            drive8(1'b0, 8'h3C, 8'h00, 1'b0);
            #1;
            n_checks++;
            if (zc8 !== 8'h3C) begin
                n_fail++;
                $display("FAIL hold_comb: z_comb=%h, required 3c", zc8);
            end
            @(posedge clk); #1;
            e = q8.pop_front();
            n_checks++;
            if (z8 !== 8'hA5 || z8 !== e.z || zv8 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: z=%h zv=%b, required z=a5 zv=0", c, z8, zv8);
            end
        end
        $display("enable hold: z=%h z_valid=%b", z8, zv8);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [7:0] a, b;
        logic s;
        for (int c = 0; c < 8; c++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            // Cycle 5 is a gap: z_valid must drop for exactly that cycle.
            drive8((c != 5), a, b, s);
            @(posedge clk); #1;
            e = q8.pop_front();
            n_checks++;
            if (z8 !== e.z || zv8 !== e.v) begin
                n_fail++;
                $display("FAIL b2b[%0d]: z=%h zv=%b, required z=%h zv=%b", c, z8, zv8, e.z, e.v);
            end
            $display("b2b %0d: en=%b sel=%b z=%h zv=%b", c, en8, s, z8, zv8);
        end
    endtask

`ifdef MUX2_SWITCH_CNT_EN
    task automatic test_counter();
        exp_t e;
        logic s_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive1(1'b1, 1'b0, 1'b1, s_seq[c]);
            @(posedge clk); #1;
            e = q1.pop_front();
            n_checks++;
            if (cnt1 !== e.cnt) begin
                n_fail++;
                $display("FAIL counter[%0d]: sw_cnt=%0d, required %0d", c, cnt1, e.cnt);
            end
        end
        n_checks++;
        if (cnt1 !== 8'd5) begin
            n_fail++;
            $display("FAIL counter_final: sw_cnt=%0d, required 5", cnt1);
        end
        // Select toggles while disabled must not count.
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        e = q1.pop_front();
        n_checks++;
        if (cnt1 !== 8'd5 || cnt1 !== e.cnt) begin
            n_fail++;
            $display("FAIL counter_disabled: sw_cnt=%0d, required 5", cnt1);
        end
        $display("counter: sw_cnt=%0d", cnt1);
    endtask

    task automatic test_saturation();
        exp_t e;
        logic s;
        do_reset();
        s = 1'b1;
        for (int c = 0; c < 9; c++) begin
            drive8(1'b1, 8'h00, 8'hFF, s);
            if (c < 5) s = ~s; // six toggles, then hold
            @(posedge clk); #1;
            e = q8.pop_front();
            n_checks++;
            if (cnt8 !== e.cnt[1:0]) begin
                n_fail++;
                $display("FAIL saturation[%0d]: sw_cnt=%0d, required %0d", c, cnt8, e.cnt);
            end
        end
        n_checks++;
        if (cnt8 !== 2'd3) begin
            n_fail++;
            $display("FAIL saturation_final: sw_cnt=%0d, required 3", cnt8);
        end
        $display("saturation: sw_cnt=%0d", cnt8);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        en1  = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0; sel1 = 1'b0;
        en8  = 1'b0; d0_8 = 8'h00; d1_8 = 8'h00; sel8 = 1'b0;
        model_reset();

        test_reset();
        test_truth_table();
        test_enable_hold();
        test_back_to_back();
`ifdef MUX2_SWITCH_CNT_EN
        test_counter();
        test_saturation();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux2_reg

// File: doc/mux2_reg.md
# mux2_reg

Registered, width-parameterised 2:1 multiplexer for the datapath select stage. Each enabled cycle it selects `d0` or `d1` by `sel` and registers the result on `z`. A combinational copy `z_comb` is provided for zero-latency consumers. An optional saturating counter tracks how often the select changes.

## Interface
- `WIDTH`, default 1, data width of `d0`, `d1`, `z`, `z_comb`.
- `CNT_W`, default 8, width of the select-change counter.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: capture enable.
- `d0` input WIDTH: data selected when `sel`=0.
- `d1` input WIDTH: data selected when `sel`=1.
- `sel` input 1: select.
- `z` output WIDTH: registered mux result.
- `z_valid` output 1: high for the cycle after a capture.
- `z_comb` output WIDTH: combinational `sel ? d1 : d0`.
- `sw_cnt` output CNT_W: select-change count. Present only with `MUX2_SWITCH_CNT_EN`.

## Operation
- `z_comb` = `d1` when `sel`=1, else `d0`, bitwise over WIDTH. It ignores `en`, `clk` and `rst`.
- When `en`=1 on a rising `clk`:
  - `z` <= `z_comb`.
  - `z_valid` <= 1.
  - `last_sel` <= `sel`.
- When `en`=0 on a rising `clk`:
  - `z` holds.
  - `z_valid` <= 0.
  - `last_sel` holds.
- Select-change counter, when compiled in:
  - Increments on an enabled capture where `sel` != `last_sel`.
  - Saturates at 2^CNT_W−1; it does not wrap.
  - The first capture after reset compares against `last_sel`=0.
- Reset: `z`=0, `z_valid`=0, `last_sel`=0, `sw_cnt`=0.
- Simultaneous events:
  - `rst` has priority over `en`.
  - Inputs changing in the same cycle as `en`: the value sampled at the edge wins.

## Timing
- `z` latency: 1 cycle from the `en`-qualified edge. `z_comb` latency: 0.
- `z_valid` is a single-cycle pulse per capture. Back-to-back captures hold it high continuously.
- `rst` assertion clears all registers immediately, independent of `clk`.
- Release is synchronised externally. The first capture happens on the first `en` edge after `rst` falls.
- Reset mid-stream discards the pending value. `z_valid` drops the same instant.

## Configuration
- `MUX2_SWITCH_CNT_EN` defined:
  - `last_sel` register, saturating counter and `sw_cnt` port are compiled in.
- Undefined:
  - Counter, `last_sel` and `sw_cnt` port are absent.
  - All other behaviour is identical.

## Structure
- Package `mux2_pkg` holds:
  - `MUX2_DEF_WIDTH`=1 and `MUX2_DEF_CNT_W`=8.
  - Typedef `mux2_sel_e` {SEL_D0=0, SEL_D1=1}.
- One sub-module, `mux2_sel_comb`: the combinational WIDTH-bit 2:1 select. It drives both `z_comb` and the `z` register input.
- The top holds the output register, valid flag and optional counter.

## Test plan
- Truth table, WIDTH=1, `en`=1. Hold each combination for 80 time units, in the order (d0,d1,sel): 000, 001, 010, 011, 101, 100, 110, 111.
  - Required `z_comb`: 0, 0, 0, 1, 0, 1, 1, 1.
  - `z` matches one cycle later.
- Reset:
  - Set `z`=1, then assert `rst` mid-cycle. `z`, `z_valid` and `sw_cnt` go to 0 before the next edge.
  - After release with `en`=1, d1=1, sel=1: `z`=1 one edge later.
- Enable hold: capture d0=0xA5 with sel=0, WIDTH=8.
  - Then set `en`=0 and change d0=0x3C. `z` stays 0xA5 and `z_valid`=0.
- Counter, with the macro defined:
  - Toggle `sel` on 5 consecutive enabled cycles starting at 1 → `sw_cnt`=5.
  - Hold `sel` constant → count unchanged.
- Saturation: CNT_W=2, 6 `sel` toggles → `sw_cnt`=3, stable.
- Macro undefined: the same bench minus `sw_cnt` passes the first three scenarios unchanged.
